// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes and debounces active-low pushbuttons into a level,
// press/release pulses and sticky press flags.
module key_debouncer #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_n,
  input  logic [WIDTH-1:0] flag_clear,
  output logic [WIDTH-1:0] key_level,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic [WIDTH-1:0] press_flag
);
  typedef enum logic [1:0] {RELEASED, ARMING, PRESSED, DISARMING} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] level_d, press_d, release_d, press_flag_d;
  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pr_d, rl_d;
    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      pr_d    = 1'b0;
      rl_d    = 1'b0;
      case (state_q)
        RELEASED: if (sync2_q[i]) begin
          state_d = ARMING;
          cnt_d   = CNT_W'(1);
        end
        ARMING: if (!sync2_q[i]) state_d = RELEASED;
        else if (cnt_q == LAST) begin
          state_d = PRESSED;
          pr_d    = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
        PRESSED: if (!sync2_q[i]) begin
          state_d = DISARMING;
          cnt_d   = CNT_W'(1);
        end
        DISARMING: if (sync2_q[i]) state_d = PRESSED;
        else if (cnt_q == LAST) begin
          state_d = RELEASED;
          rl_d    = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
        default: state_d = RELEASED;
      endcase
    end
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end
    assign level_d[i]   = (state_d == PRESSED) || (state_d == DISARMING);
    assign press_d[i]   = pr_d;
    assign release_d[i] = rl_d;
  end
  // a press pulse coinciding with a clear keeps the flag set
  assign press_flag_d = key_press | (press_flag & ~flag_clear);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      press_flag  <= '0;
    end else begin
      sync1_q     <= ~key_n;
      sync2_q     <= sync1_q;
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
      press_flag  <= press_flag_d;
    end
  end
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed self-checking bench for key_debouncer with
// DEBOUNCE_CYCLES=4; outputs are checked as {level, press, release, flag}.
module tb_key_debouncer;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] key_n, flag_clear;
  logic [1:0] key_level, key_press, key_release, press_flag;
  logic [7:0] obs;
  int n_checks = 0;
  int n_fail   = 0;

  key_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .key_n(key_n), .flag_clear(flag_clear),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .press_flag(press_flag)
  );

  always #5 clk = ~clk;
  assign obs = {key_level, key_press, key_release, press_flag};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] exp;
    reset_n = 1'b0; key_n = 2'b00; flag_clear = 2'b00;
    for (int n = 1; n <= 3; n++) begin
      tick();
      n_checks++;
      if (obs !== 8'h00) begin
        n_fail++; $display("FAIL reset_hold[%0d]: got %b want %b", n, obs, 8'h00);
      end
    end
    reset_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      exp = (n == 6) ? {2'b11, 2'b11, 2'b00, 2'b00} : 8'h00;
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL reset_accept[%0d]: got %b want %b", n, obs, exp);
      end
    end
    tick();
    n_checks++;
    if (obs !== {2'b11, 2'b00, 2'b00, 2'b11}) begin
      n_fail++; $display("FAIL reset_flag: got %b want %b", obs, {2'b11, 2'b00, 2'b00, 2'b11});
    end
    key_n = 2'b11;
    for (int n = 1; n <= 6; n++) begin
      tick();
      exp = (n == 6) ? {2'b00, 2'b00, 2'b11, 2'b11} : {2'b11, 2'b00, 2'b00, 2'b11};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL reset_release[%0d]: got %b want %b", n, obs, exp);
      end
    end
    flag_clear = 2'b11;
    tick();
    flag_clear = 2'b00;
    n_checks++;
    if (obs !== 8'h00) begin
      n_fail++; $display("FAIL reset_clear: got %b want %b", obs, 8'h00);
    end
  endtask

  task automatic test_clean_press;
    logic [7:0] exp;
    key_n = 2'b10;
    for (int n = 1; n <= 6; n++) begin
      tick();
      exp = (n == 6) ? {2'b01, 2'b01, 2'b00, 2'b00} : 8'h00;
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL clean_press[%0d]: got %b want %b", n, obs, exp);
      end
    end
    tick();
    n_checks++;
    if (obs !== {2'b01, 2'b00, 2'b00, 2'b01}) begin
      n_fail++; $display("FAIL clean_flag: got %b want %b", obs, {2'b01, 2'b00, 2'b00, 2'b01});
    end
    key_n = 2'b11;
    for (int n = 1; n <= 6; n++) begin
      tick();
      exp = (n == 6) ? {2'b00, 2'b00, 2'b01, 2'b01} : {2'b01, 2'b00, 2'b00, 2'b01};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL clean_release[%0d]: got %b want %b", n, obs, exp);
      end
    end
    tick();
    n_checks++;
    if (obs !== {2'b00, 2'b00, 2'b00, 2'b01}) begin
      n_fail++; $display("FAIL clean_after: got %b want %b", obs, {2'b00, 2'b00, 2'b00, 2'b01});
    end
  endtask

  task automatic test_bounce_reject;
    logic [1:0] seq [14] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11,
                             2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    for (int n = 0; n < 14; n++) begin
      key_n = seq[n];
      tick();
      n_checks++;
      if (obs !== {2'b00, 2'b00, 2'b00, 2'b01}) begin
        n_fail++; $display("FAIL bounce_reject[%0d]: got %b want %b", n, obs, {2'b00, 2'b00, 2'b00, 2'b01});
      end
    end
  endtask

  task automatic test_bounce_settle;
    logic [7:0] exp;
    logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b01, 2'b11};
    for (int n = 0; n < 4; n++) begin
      key_n = seq[n];
      tick();
      n_checks++;
      if (obs !== {2'b00, 2'b00, 2'b00, 2'b01}) begin
        n_fail++; $display("FAIL settle_toggle[%0d]: got %b want %b", n, obs, {2'b00, 2'b00, 2'b00, 2'b01});
      end
    end
    key_n = 2'b01;
    for (int n = 1; n <= 6; n++) begin
      tick();
      exp = (n == 6) ? {2'b10, 2'b10, 2'b00, 2'b01} : {2'b00, 2'b00, 2'b00, 2'b01};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL settle_press[%0d]: got %b want %b", n, obs, exp);
      end
    end
    tick();
    n_checks++;
    if (obs !== {2'b10, 2'b00, 2'b00, 2'b11}) begin
      n_fail++; $display("FAIL settle_single: got %b want %b", obs, {2'b10, 2'b00, 2'b00, 2'b11});
    end
    key_n = 2'b11;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp = (n == 6) ? {2'b00, 2'b00, 2'b10, 2'b11} :
            (n == 7) ? {2'b00, 2'b00, 2'b00, 2'b11} : {2'b10, 2'b00, 2'b00, 2'b11};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL settle_release[%0d]: got %b want %b", n, obs, exp);
      end
    end
  endtask

  task automatic test_clear_race;
    logic [7:0] exp;
    flag_clear = 2'b01;
    tick();
    flag_clear = 2'b00;
    n_checks++;
    if (obs !== {2'b00, 2'b00, 2'b00, 2'b10}) begin
      n_fail++; $display("FAIL race_preclear: got %b want %b", obs, {2'b00, 2'b00, 2'b00, 2'b10});
    end
    key_n = 2'b10;
    for (int n = 1; n <= 6; n++) begin
      tick();
      exp = (n == 6) ? {2'b01, 2'b01, 2'b00, 2'b10} : {2'b00, 2'b00, 2'b00, 2'b10};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL race_press[%0d]: got %b want %b", n, obs, exp);
      end
    end
    flag_clear = 2'b01;
    tick();
    n_checks++;
    if (obs !== {2'b01, 2'b00, 2'b00, 2'b11}) begin
      n_fail++; $display("FAIL race_set_wins: got %b want %b", obs, {2'b01, 2'b00, 2'b00, 2'b11});
    end
    tick();
    flag_clear = 2'b00;
    n_checks++;
    if (obs !== {2'b01, 2'b00, 2'b00, 2'b10}) begin
      n_fail++; $display("FAIL race_lone_clear: got %b want %b", obs, {2'b01, 2'b00, 2'b00, 2'b10});
    end
    key_n = 2'b11;
    repeat (7) tick();
    n_checks++;
    if (obs !== {2'b00, 2'b00, 2'b00, 2'b10}) begin
      n_fail++; $display("FAIL race_release: got %b want %b", obs, {2'b00, 2'b00, 2'b00, 2'b10});
    end
  endtask

  task automatic test_simultaneous_reset;
    logic [7:0] exp;
    key_n = 2'b00;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp = (n == 6) ? {2'b11, 2'b11, 2'b00, 2'b10} :
            (n == 7) ? {2'b11, 2'b00, 2'b00, 2'b11} : {2'b00, 2'b00, 2'b00, 2'b10};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL simul_press[%0d]: got %b want %b", n, obs, exp);
      end
    end
    key_n = 2'b11;
    repeat (7) tick();
    key_n = 2'b10;
    for (int n = 1; n <= 4; n++) begin
      tick();
      n_checks++;
      if (obs !== {2'b00, 2'b00, 2'b00, 2'b11}) begin
        n_fail++; $display("FAIL mid_arming[%0d]: got %b want %b", n, obs, {2'b00, 2'b00, 2'b00, 2'b11});
      end
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_checks++;
    if (obs !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset: got %b want %b", obs, 8'h00);
    end
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp = (n == 6) ? {2'b01, 2'b01, 2'b00, 2'b00} :
            (n == 7) ? {2'b01, 2'b00, 2'b00, 2'b01} : 8'h00;
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL held_reaccept[%0d]: got %b want %b", n, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_bounce_settle();
    test_clear_race();
    test_simultaneous_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
